// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: shares the core's unified byte-addressed memory between instruction fetch
// and data requests, one transaction at a time, with data priority and a fetch starvation guard.
module tinker_mem_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rsp_data,
   input  logic              d_req_valid,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [63:0]       d_req_wdata,
   output logic              d_req_ready,
   output logic              d_rsp_valid,
   output logic [63:0]       d_rsp_data,
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic              mem_req_size,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [63:0]       mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [63:0]       mem_rsp_data,
   output logic [1:0]        o_dbg_state,
   output logic [3:0]        o_dbg_cnt
);

   // Handshake: a request transfers on the cycle where valid and ready are both 1; the requester
   // holds valid and its fields until then, and ready is only ever raised while the arbiter is idle.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      RESP     = 2'd3
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t            r_state;
   state_t            w_next;
   logic              w_grant_if;
   logic              w_grant_d;
   logic [3:0]        r_cnt;
   logic              r_owner_d;
   logic              r_we;
   logic              r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [63:0]       r_wdata;
   logic [31:0]       r_if_rsp_data;
   logic [63:0]       r_d_rsp_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_grant_if    = 1'b0;
      w_grant_d     = 1'b0;
      if_req_ready  = 1'b0;
      d_req_ready   = 1'b0;
      mem_req_valid = 1'b0;
      if_rsp_valid  = 1'b0;
      d_rsp_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            // rst gating keeps ready low while reset holds the FSM in IDLE
            if (!rst) begin
               if (if_req_valid && (!d_req_valid || r_cnt >= MAX_WAIT_C)) w_grant_if = 1'b1;
               else if (d_req_valid)                                      w_grant_d  = 1'b1;
            end
            if_req_ready = w_grant_if;
            d_req_ready  = w_grant_d;
            if (w_grant_if || w_grant_d) w_next = ISSUE;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) w_next = r_we ? RESP : WAIT_RSP;
         end
         WAIT_RSP: begin
            if (mem_rsp_valid) w_next = RESP;
         end
         RESP: begin
            if_rsp_valid = !r_owner_d;
            d_rsp_valid  = r_owner_d;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Counts consecutive cycles a pending fetch has gone without a grant, busy cycles included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              r_cnt <= 4'd0;
      else if (!if_req_valid || w_grant_if) r_cnt <= 4'd0;
      else if (r_cnt != 4'hF)               r_cnt <= r_cnt + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner_d <= 1'b0;
         r_we      <= 1'b0;
         r_size    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= 64'd0;
      end else if (w_grant_if) begin
         r_owner_d <= 1'b0;
         r_we      <= 1'b0;
         r_size    <= 1'b0;
         r_addr    <= if_req_addr;
         r_wdata   <= 64'd0;
      end else if (w_grant_d) begin
         r_owner_d <= 1'b1;
         r_we      <= d_req_we;
         r_size    <= 1'b1;
         r_addr    <= d_req_addr;
         r_wdata   <= d_req_wdata;
      end
   end

   // Response data registers only change when a response is produced, so they hold between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_rsp_data <= 32'd0;
         r_d_rsp_data  <= 64'd0;
      end else if (r_state == WAIT_RSP && mem_rsp_valid) begin
         if (r_owner_d) r_d_rsp_data  <= mem_rsp_data;
         else           r_if_rsp_data <= mem_rsp_data[31:0];
      end else if (r_state == ISSUE && mem_req_ready && r_we) begin
         r_d_rsp_data <= 64'd0;
      end
   end

   assign mem_req_we    = r_we;
   assign mem_req_size  = r_size;
   assign mem_req_addr  = r_addr;
   assign mem_req_wdata = r_wdata;
   assign if_rsp_data   = r_if_rsp_data;
   assign d_rsp_data    = r_d_rsp_data;
   assign o_dbg_state   = r_state;
   assign o_dbg_cnt     = r_cnt;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: directed and random traffic checked against a transaction-level model
// of the arbiter, with a behavioural memory answering on the memory port.
module tb_tinker_mem_arbiter;
   localparam int ADDR_W   = 64;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              if_req_valid, if_req_ready, if_rsp_valid;
   logic [ADDR_W-1:0] if_req_addr;
   logic [31:0]       if_rsp_data;
   logic              d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
   logic [ADDR_W-1:0] d_req_addr;
   logic [63:0]       d_req_wdata, d_rsp_data;
   logic              mem_req_valid, mem_req_we, mem_req_size, mem_req_ready, mem_rsp_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [63:0]       mem_req_wdata, mem_rsp_data;
   logic [1:0]        o_dbg_state;
   logic [3:0]        o_dbg_cnt;

   always #5 clk = ~clk;

   tinker_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_size(mem_req_size),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .o_dbg_state(o_dbg_state), .o_dbg_cnt(o_dbg_cnt)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // memory environment
   logic [63:0] mem_arr [logic [63:0]];
   int          m_stall = 0, stall_max = 0, rsp_min = 0, rsp_max = 0, m_cd = 0;
   bit          m_pend = 0, spurious = 0;
   logic [63:0] m_val = 64'd0;

   // requesters
   bit          if_pend = 0, d_pend = 0, d_w = 0, auto_req = 0, d_always = 0;
   int          if_rate = 0, d_rate = 0;
   logic [63:0] if_a = 64'd0, d_a = 64'd0, d_wd = 64'd0;

   // reference model: the one outstanding transaction and what the arbiter owes next cycle
   bit          t_issue = 0, t_wait = 0, t_resp = 0, t_fetch = 0, t_we = 0;
   logic [63:0] t_addr = 64'd0, t_wd = 64'd0, t_exp = 64'd0;
   int          lost = 0;
   logic [31:0] last_if = 32'd0;
   logic [63:0] last_d = 64'd0;
   int          acc_cyc = 0, rsp_cyc = 0, n_if_acc = 0, n_d_acc = 0, n_rsp = 0, n_dut_rsp = 0;
   bit          last_acc_fetch = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mem_val(input logic [63:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {a[31:0] ^ 32'hC3A5_5A3C, a[31:0] * 32'd2654435761};
   endfunction

   function automatic bit busy();
      return t_issue || t_wait || t_resp;
   endfunction

   task automatic gen_req();
      if (auto_req) begin
         if (!if_pend && $urandom_range(0, 99) < if_rate) begin
            if_pend = 1'b1;
            if_a    = 64'h1000 + (64'($urandom_range(0, 63)) << 2);
         end
         if (!d_pend && $urandom_range(0, 99) < d_rate) begin
            d_pend = 1'b1;
            d_w    = 1'($urandom_range(0, 1));
            d_a    = 64'h1000 + (64'($urandom_range(0, 31)) << 3);
            d_wd   = {$urandom, $urandom};
         end
      end
      if (d_always && !d_pend) begin
         d_pend = 1'b1;
         d_w    = 1'($urandom_range(0, 1));
         d_a    = 64'h1000 + (64'($urandom_range(0, 31)) << 3);
         d_wd   = {$urandom, $urandom};
      end
      if_req_valid = if_pend;
      if_req_addr  = if_pend ? if_a : {$urandom, $urandom};
      d_req_valid  = d_pend;
      d_req_we     = d_pend ? d_w : 1'($urandom_range(0, 1));
      d_req_addr   = d_pend ? d_a : {$urandom, $urandom};
      d_req_wdata  = d_pend ? d_wd : {$urandom, $urandom};
   endtask

   task automatic gen_mem();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom};
      if (mem_req_valid) begin
         if (m_stall > 0) m_stall--;
         else             mem_req_ready = 1'b1;
      end
      if (m_pend) begin
         if (m_cd > 0) m_cd--;
         else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = m_val;
            m_pend        = 1'b0;
         end
      end else if (spurious && $urandom_range(0, 5) == 0) begin
         mem_rsp_valid = 1'b1;
      end
   endtask

   task automatic check_cycle();
      bit e_if_rdy, e_d_rdy, acc_if, acc_d, n_issue, n_wait, n_resp;
      e_if_rdy = !busy() && if_req_valid && (!d_req_valid || lost >= MAX_WAIT);
      e_d_rdy  = !busy() && d_req_valid && !e_if_rdy;
      chk("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
      chk("d_req_ready", 64'(d_req_ready), 64'(e_d_rdy));
      chk("starve_cnt", 64'(o_dbg_cnt), 64'(lost));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(t_issue));
      if (t_issue) begin
         chk("mem_req_addr", mem_req_addr, t_addr);
         chk("mem_req_we", 64'(mem_req_we), 64'(t_we));
         chk("mem_req_size", 64'(mem_req_size), 64'(!t_fetch));
         if (t_we) chk("mem_req_wdata", mem_req_wdata, t_wd);
      end
      chk("if_rsp_valid", 64'(if_rsp_valid), 64'(t_resp && t_fetch));
      chk("d_rsp_valid", 64'(d_rsp_valid), 64'(t_resp && !t_fetch));
      if (if_rsp_valid || d_rsp_valid) n_dut_rsp++;
      if (t_resp) begin
         if (t_fetch) last_if = t_exp[31:0];
         else         last_d  = t_exp;
         rsp_cyc = cyc;
         n_rsp++;
      end
      chk("if_rsp_data", 64'(if_rsp_data), 64'(last_if));
      chk("d_rsp_data", d_rsp_data, last_d);

      if (mem_req_valid && mem_req_ready) begin
         m_stall = $urandom_range(0, stall_max);
         if (mem_req_we) mem_arr[mem_req_addr] = mem_req_wdata;
         else begin
            m_pend = 1'b1;
            m_cd   = $urandom_range(rsp_min, rsp_max);
            m_val  = mem_val(mem_req_addr);
         end
      end

      acc_if = if_req_valid && e_if_rdy;
      acc_d  = d_req_valid && e_d_rdy;
      if (!if_req_valid || acc_if) lost = 0;
      else if (lost < 15)          lost++;
      n_issue = 1'b0;
      n_wait  = 1'b0;
      n_resp  = 1'b0;
      if (t_issue) begin
         if (mem_req_ready) begin
            if (t_we) n_resp = 1'b1;
            else      n_wait = 1'b1;
         end else n_issue = 1'b1;
      end
      if (t_wait) begin
         if (mem_rsp_valid) n_resp = 1'b1;
         else               n_wait = 1'b1;
      end
      if (acc_if || acc_d) begin
         n_issue        = 1'b1;
         t_fetch        = acc_if;
         t_we           = acc_d && d_req_we;
         t_addr         = acc_if ? if_req_addr : d_req_addr;
         t_wd           = d_req_wdata;
         t_exp          = t_we ? 64'd0 : mem_val(t_addr);
         acc_cyc        = cyc;
         last_acc_fetch = acc_if;
         if (acc_if) begin n_if_acc++; if_pend = 1'b0; end
         else        begin n_d_acc++;  d_pend  = 1'b0; end
      end
      t_issue = n_issue;
      t_wait  = n_wait;
      t_resp  = n_resp;
      cyc++;
   endtask

   task automatic body();
      gen_req();
      gen_mem();
      #1;
      check_cycle();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      body();
   endtask

   task automatic wait_rsp(input string tag, input int budget);
      int n0;
      n0 = n_rsp;
      for (int i = 0; i < budget && n_rsp == n0; i++) tick();
      checks++;
      assert (n_rsp > n0) else begin
         failures++;
         $error("FAIL %s_timeout observed=%0d responses expected=%0d", tag, n_rsp - n0, 1);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (busy() || if_pend || d_pend); i++) tick();
      checks++;
      assert (!busy() && !if_pend && !d_pend) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d busy expected=%0d", busy(), 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_if_req_ready"}, 64'(if_req_ready), 64'd0);
      chk({tag, "_d_req_ready"}, 64'(d_req_ready), 64'd0);
      chk({tag, "_if_rsp_valid"}, 64'(if_rsp_valid), 64'd0);
      chk({tag, "_d_rsp_valid"}, 64'(d_rsp_valid), 64'd0);
      chk({tag, "_if_rsp_data"}, 64'(if_rsp_data), 64'd0);
      chk({tag, "_d_rsp_data"}, d_rsp_data, 64'd0);
      chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
      chk({tag, "_mem_req_we"}, 64'(mem_req_we), 64'd0);
      chk({tag, "_mem_req_size"}, 64'(mem_req_size), 64'd0);
      chk({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
      chk({tag, "_mem_req_wdata"}, mem_req_wdata, 64'd0);
      chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
      chk({tag, "_cnt"}, 64'(o_dbg_cnt), 64'd0);
   endtask

   task automatic clear_model();
      t_issue = 1'b0;
      t_wait  = 1'b0;
      t_resp  = 1'b0;
      lost    = 0;
      last_if = 32'd0;
      last_d  = 64'd0;
   endtask

   initial begin
      int n0;
      if_req_valid  = 1'b1;
      if_req_addr   = 64'h2000;
      d_req_valid   = 1'b0;
      d_req_we      = 1'b0;
      d_req_addr    = 64'd0;
      d_req_wdata   = 64'd0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 64'd0;
      mem_arr[64'h2000]  = 64'h0000_0000_DEADBEEF;
      mem_arr[64'h80000] = 64'h1122_3344_5566_7788;

      // power-on reset with a fetch already requesting
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 check_reset_outputs("por");
      if_pend = 1'b1;
      if_a    = 64'h2000;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      body();
      chk("first_idle_if_ready", 64'(if_req_ready), 64'd1);
      wait_rsp("fetch_2000", 20);
      chk("fetch_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
      chk("fetch_data", 64'(if_rsp_data), 64'hDEADBEEF);
      chk("fetch_no_d_rsp", 64'(d_rsp_valid), 64'd0);

      // simultaneous requests: data first, fetch in the next idle cycle
      if_pend = 1'b1;  if_a = 64'h2004;
      d_pend  = 1'b1;  d_w  = 1'b0;  d_a = 64'h80000;
      tick();
      chk("both_first_grant_fetch", 64'(last_acc_fetch), 64'd0);
      wait_rsp("data_read_80000", 20);
      chk("data_read_data", d_rsp_data, 64'h1122_3344_5566_7788);
      tick();
      chk("both_second_grant_fetch", 64'(last_acc_fetch), 64'd1);
      chk("fetch_grant_after_resp", 64'(acc_cyc - rsp_cyc), 64'd1);
      wait_rsp("fetch_2004", 20);

      // write with a stalled memory port
      m_stall = 3;
      d_pend  = 1'b1;  d_w = 1'b1;  d_a = 64'h7FFF8;  d_wd = 64'h2004;
      wait_rsp("data_write_7fff8", 20);
      chk("write_rsp_data", d_rsp_data, 64'd0);
      chk("write_latency", 64'(rsp_cyc - acc_cyc), 64'd5);
      chk("write_mem_content", mem_val(64'h7FFF8), 64'h2004);

      // starvation guard under continuous data traffic
      d_always = 1'b1;
      if_pend  = 1'b1;
      if_a     = 64'h3000;
      n0       = n_if_acc;
      for (int i = 0; i < 60 && n_if_acc == n0; i++) tick();
      checks++;
      assert (n_if_acc > n0) else begin
         failures++;
         $error("FAIL starve_fetch_granted observed=%0d expected=%0d", n_if_acc - n0, 1);
      end
      tick();
      chk("starve_cnt_after_grant", 64'(o_dbg_cnt), 64'd0);
      repeat (20) tick();
      d_always = 1'b0;
      drain();

      // reset while waiting for read data; the late memory response must be ignored
      rsp_min = 3;
      rsp_max = 3;
      d_pend  = 1'b1;  d_w = 1'b0;  d_a = 64'h80000;
      for (int i = 0; i < 20 && !t_wait; i++) tick();
      checks++;
      assert (t_wait) else begin
         failures++;
         $error("FAIL reach_wait_rsp observed=%0d expected=%0d", t_wait, 1);
      end
      #1 rst = 1'b1;
      if_req_valid  = 1'b1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      #1 check_reset_outputs("mid");
      @(posedge clk);
      #1 rst = 1'b0;
      clear_model();
      if_pend = 1'b0;
      d_pend  = 1'b0;
      n0      = n_dut_rsp;
      body();
      repeat (7) tick();
      chk("mid_reset_no_rsp", 64'(n_dut_rsp - n0), 64'd0);
      chk("mid_reset_stale_rsp_seen", 64'(m_pend), 64'd0);
      chk("mid_reset_state_idle", 64'(o_dbg_state), 64'd0);

      // random traffic, then data-heavy random traffic
      rsp_min   = 0;
      rsp_max   = 2;
      stall_max = 2;
      spurious  = 1'b1;
      auto_req  = 1'b1;
      if_rate   = 40;
      d_rate    = 50;
      repeat (1500) tick();
      if_rate = 60;
      d_rate  = 95;
      repeat (500) tick();
      auto_req = 1'b0;
      drain();
      spurious = 1'b0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tinker_mem_arbiter.md
Name: tinker_mem_arbiter

Overview:
Arbitrates the core's single unified byte-addressed memory between the instruction-fetch requester and the data requester (loads, stores, call/return stack traffic). Requests are accepted with a valid/ready handshake and forwarded to the memory port one at a time. Read data is routed back to the requester that issued the read. Data requests have priority, and a starvation counter guarantees that instruction fetch makes forward progress.

Parameters:
ADDR_W, 64, address width for both requesters and the memory port
MAX_WAIT, 4, consecutive lost-arbitration cycles after which a pending fetch overrides data priority (range 1..15)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous, active-high
if_req_valid  in  1  fetch request pending
if_req_addr  in  ADDR_W  fetch address; 4-byte read
if_req_ready  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  one-cycle pulse: fetched instruction valid
if_rsp_data  out  32  instruction word, little-endian
d_req_valid  in  1  data request pending
d_req_we  in  1  1 = 8-byte write, 0 = 8-byte read
d_req_addr  in  ADDR_W  data address
d_req_wdata  in  64  store data
d_req_ready  out  1  data request accepted this cycle
d_rsp_valid  out  1  one-cycle pulse: read data valid or write done
d_rsp_data  out  64  load data; 0 for writes
mem_req_valid  out  1  memory request valid
mem_req_we  out  1  memory write enable
mem_req_size  out  1  0 = 4 bytes, 1 = 8 bytes
mem_req_addr  out  ADDR_W  memory address
mem_req_wdata  out  64  memory write data
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  memory read data valid
mem_rsp_data  in  64  memory read data

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE, all valid/ready outputs 0, data/address outputs 0
  - starvation counter 0, owner 0, pending transaction dropped
- Reset mid-transaction: no response is ever produced for the dropped request.
- States: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE, grant selection (combinational from inputs and counter):
  - grant = fetch if if_req_valid && (!d_req_valid || cnt >= MAX_WAIT).
  - Otherwise grant = data if d_req_valid.
- IDLE, acceptance:
  - The granted requester's ready is 1 in the same cycle; the other requester's ready is 0.
  - At the clock edge: latch addr, we, wdata, size (fetch: 0, we = 0; data: 1) and owner, then go to ISSUE.
  - Ready outputs are 0 in every state other than IDLE.
- Starvation counter, updated every cycle:
  - Clears when fetch is granted or when if_req_valid = 0.
  - Increments, saturating at 15, when if_req_valid = 1 and fetch is not granted. This includes cycles spent in ISSUE, WAIT_RSP and RESP.
- ISSUE:
  - mem_req_valid = 1 with the latched fields held stable until mem_req_ready = 1.
  - On handshake: a read goes to WAIT_RSP; a write goes to RESP.
- WAIT_RSP:
  - mem_req_valid = 0.
  - On mem_rsp_valid = 1, latch mem_rsp_data and go to RESP.
- RESP:
  - Exactly one cycle; go to IDLE.
  - Owner fetch: if_rsp_valid = 1, if_rsp_data = latched[31:0].
  - Owner data: d_rsp_valid = 1, d_rsp_data = latched data for reads, 0 for writes.
- Response outputs: rsp_valid outputs are 0 outside RESP. Rsp_data outputs hold their last value.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Simultaneous requests resolve by the grant rule above; the loser's request is not consumed.
- Back-to-back throughput: a read with zero-wait memory takes 4 cycles from acceptance to the next acceptance.
- Latency: with mem_req_ready = 1 and mem_rsp_valid returned the cycle after the handshake:
  - accept edge T
  - ISSUE in cycle T+1
  - WAIT_RSP in cycle T+2
  - rsp_valid in cycle T+3
- Addresses are forwarded unchanged; alignment is not checked. The memory handles little-endian byte assembly.

Test Plan:
- Reset with if_req_valid = 1 held: all outputs 0 during reset; after release if_req_ready = 1 in the first IDLE cycle.
- Fetch at 0x2000, memory returns 0x00000000_DEADBEEF one cycle after handshake: mem_req_size = 0; if_rsp_valid pulses exactly 3 cycles after acceptance with if_rsp_data = 0xDEADBEEF; d_rsp_valid stays 0.
- Both valid in the same cycle, data read at 0x80000 returning 0x1122334455667788: data is granted first; d_rsp_data = 0x1122334455667788; fetch is granted in the following IDLE cycle.
- Data write at 0x7FFF8 with wdata 0x2004, mem_req_ready delayed 3 cycles: mem_req fields stay stable throughout; d_rsp_valid = 1 with d_rsp_data = 0 one cycle after the handshake; mem_rsp_valid is never required.
- MAX_WAIT = 4, d_req_valid held high continuously, if_req_valid held high: fetch is granted no later than the first IDLE cycle with cnt >= 4; after that grant cnt returns to 0.
- rst asserted during WAIT_RSP, then mem_rsp_valid pulsed after release: no if_rsp_valid or d_rsp_valid pulse; state is IDLE.
